// File: rtl/rgbw_pkg.sv
// rgbw_pkg: shared constants and FSM state type for the RGBW command transmitter.
package rgbw_pkg;
  localparam int         FRAME_BYTES = 4;
  localparam logic [7:0] CRC8_POLY   = 8'h07;
  localparam logic [7:0] CRC8_INIT   = 8'h00;
  localparam int         BIT_CNT_W   = 6;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} tx_state_t;
endpackage

// File: rtl/rgbw_crc8.sv
// rgbw_crc8: serial CRC-8, one message bit per enable, MSB first, with synchronous clear.
module rgbw_crc8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);
  import rgbw_pkg::*;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) crc <= CRC8_INIT;
    else if (clr) crc <= CRC8_INIT;
    else if (en) crc <= {crc[6:0], 1'b0} ^ (crc[7] ^ din ? CRC8_POLY : 8'h00);
endmodule

// File: rtl/rgbw_cmd_tx.sv
// rgbw_cmd_tx: SPI mode-0 transmitter sending one 32-bit RGBW word per frame, MSB first.
// Define RGBW_TX_CRC_EN to append a CRC-8 byte after the W byte.
module rgbw_cmd_tx #(
  parameter int CLK_DIV     = 4,
  parameter int FRAME_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n
);
  import rgbw_pkg::*;
  localparam int DW = $clog2(CLK_DIV + 1);
`ifdef RGBW_TX_CRC_EN
  localparam int N = FRAME_BYTES * 8 + 8;
`else
  localparam int N = FRAME_BYTES * 8;
`endif
  tx_state_t state, nxt;
  logic [DW-1:0] div;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [30:0] sr;
  logic ph, ph_n, accept, div_end, fall, last, nb;
  assign in_ready = state == IDLE;
  assign accept = in_valid && in_ready;
  assign div_end = div == DW'(CLK_DIV - 1);
  assign fall = state == SHIFT && ph && div_end;
  assign last = bit_cnt == BIT_CNT_W'(N - 1);
  // sr holds the bits still to be sent; the bit on the line lives in mosi
`ifdef RGBW_TX_CRC_EN
  logic [7:0] crc;
  // poly bit 7 is zero, so the CRC MSB after any update is the old bit 6
  assign nb = bit_cnt < BIT_CNT_W'(31) ? sr[30] : crc[6];
  rgbw_crc8 u_crc (
    .clk(clk),
    .rst_n(rst_n),
    .clr(accept),
    .en(fall),
    .din(mosi),
    .crc(crc)
  );
`else
  assign nb = sr[30];
`endif
  always_comb begin
    nxt = state;
    ph_n = ph;
    if (state == IDLE) nxt = accept ? SETUP : IDLE;
    else if (div_end) nxt = state == SETUP ? SHIFT : state == SHIFT ? (ph && last ? HOLD : SHIFT) : state == HOLD ? GAP : IDLE;
    ph_n = state == SETUP ? 1'b1 : (state == SHIFT && div_end) ? ~ph : ph;
  end
  // outputs are registered from the next-state view so they line up with the state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      div <= '0;
      ph <= 1'b0;
      bit_cnt <= '0;
      sr <= '0;
      sclk <= 1'b0;
      mosi <= 1'b0;
      cs_n <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      div <= state == IDLE || div_end ? '0 : div + 1'b1;
      ph <= ph_n;
      bit_cnt <= accept ? '0 : fall ? bit_cnt + 1'b1 : bit_cnt;
      sr <= accept ? in_data[30:0] : fall ? {sr[29:0], 1'b0} : sr;
      sclk <= nxt == SHIFT && ph_n;
      mosi <= accept ? in_data[31] : fall ? !last && nb : mosi;
      cs_n <= !(nxt == SETUP || nxt == SHIFT || nxt == HOLD);
      busy <= nxt != IDLE;
      done <= state == HOLD && div_end;
    end
endmodule

// File: tb/tb_rgbw_cmd_tx.sv
// tb_rgbw_cmd_tx: directed self-checking bench for rgbw_cmd_tx at CLK_DIV=4 and CLK_DIV=1.
module tb_rgbw_cmd_tx;
`ifdef RGBW_TX_CRC_EN
  localparam int NB = 40, LOW4 = 324, RDY4 = 329, LOW1 = 81;
`else
  localparam int NB = 32, LOW4 = 260, RDY4 = 265, LOW1 = 65;
`endif
  logic clk = 0, rst_n = 0, in_valid = 0, sel = 0;
  logic [31:0] in_data = '0;
  logic rdy4, busy4, done4, sclk4, mosi4, cs4;
  logic rdy1, busy1, done1, sclk1, mosi1, cs1;
  logic o_ready, o_busy, o_done, o_sclk, o_mosi, o_cs_n;
  int vec = 0, err = 0;
  int c_fall, c_rise, c_rdy, c_done, c_first, n_bits, n_done, n_glitch, n_tog;
  logic b_first, b_end;
  logic [39:0] cap;

  always #5 clk = ~clk;

  rgbw_cmd_tx #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy4),
    .busy(busy4), .done(done4), .sclk(sclk4), .mosi(mosi4), .cs_n(cs4)
  );
  rgbw_cmd_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .busy(busy1), .done(done1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs1)
  );

  always_comb begin
    o_ready = sel ? rdy1 : rdy4;
    o_busy = sel ? busy1 : busy4;
    o_done = sel ? done1 : done4;
    o_sclk = sel ? sclk1 : sclk4;
    o_mosi = sel ? mosi1 : mosi4;
    o_cs_n = sel ? cs1 : cs4;
  end

`ifdef RGBW_TX_CRC_EN
  function automatic logic [7:0] crc8(input logic [31:0] w);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 31; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ w[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction
`endif

  function automatic logic [39:0] frame_of(input logic [31:0] w);
`ifdef RGBW_TX_CRC_EN
    return {w, crc8(w)};
`else
    return {8'h00, w};
`endif
  endfunction

  // offer one word; the accepting edge is the next posedge
  task automatic launch(input logic [31:0] w, input bit hold);
    @(negedge clk);
    in_data = w;
    in_valid = 1;
    @(posedge clk);
    #1 if (!hold) in_valid = 0;
  endtask

  // c counts cycles after the accepting edge; stops once in_ready is back
  task automatic capture(input int budget);
    logic ps, pm;
    c_fall = -1; c_rise = -1; c_rdy = -1; c_done = -1; c_first = -1;
    n_bits = 0; n_done = 0; n_glitch = 0; n_tog = 0; cap = '0;
    ps = 0; pm = 0; b_first = 0; b_end = 1;
    for (int c = 1; c <= budget && c_rdy < 0; c++) begin
      @(negedge clk);
      if (c == 1) b_first = o_busy;
      if (o_sclk && !ps) begin
        cap = {cap[38:0], o_mosi};
        n_bits++;
        if (c_first < 0) c_first = c;
      end
      if (o_sclk && ps && o_mosi !== pm) n_glitch++;
      if (o_sclk !== ps) n_tog++;
      if (!o_cs_n && c_fall < 0) c_fall = c;
      if (o_cs_n && c_fall >= 0 && c_rise < 0) c_rise = c;
      if (o_done) begin n_done++; c_done = c; end
      if (o_ready) begin c_rdy = c; b_end = o_busy; end
      ps = o_sclk;
      pm = o_mosi;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vec++;
    if ({o_sclk, o_mosi, o_cs_n, o_busy, o_done, o_ready} !== 6'b001001) begin
      err++;
      $display("FAIL reset_outputs: sclk,mosi,cs_n,busy,done,ready=%b want 001001", {o_sclk, o_mosi, o_cs_n, o_busy, o_done, o_ready});
    end
    rst_n = 1;
    @(negedge clk);
    vec++;
    if ({o_cs_n, o_ready, o_busy, cs1, rdy1} !== 5'b11011) begin
      err++;
      $display("FAIL reset_release: cs_n,ready,busy,cs1,rdy1=%b want 11011", {o_cs_n, o_ready, o_busy, cs1, rdy1});
    end
  endtask

  task automatic test_single_frame;
    launch(32'hFF8000AA, 0);
    capture(600);
    vec++;
    if (cap !== frame_of(32'hFF8000AA) || n_bits != NB) begin
      err++;
      $display("FAIL frame_bits: got %h (%0d bits) want %h (%0d bits)", cap, n_bits, frame_of(32'hFF8000AA), NB);
    end
    vec++;
    if (c_fall != 1 || c_first != 5) begin
      err++;
      $display("FAIL frame_start: cs_n fall %0d sclk rise %0d want 1 and 5", c_fall, c_first);
    end
    vec++;
    if (c_rise - c_fall != LOW4) begin
      err++;
      $display("FAIL cs_low_len: got %0d want %0d", c_rise - c_fall, LOW4);
    end
    vec++;
    if (n_done != 1 || c_done != c_rise) begin
      err++;
      $display("FAIL done_pulse: %0d pulses at %0d want 1 at %0d", n_done, c_done, c_rise);
    end
    vec++;
    if (c_rdy != RDY4 || b_end !== 1'b0 || b_first !== 1'b1) begin
      err++;
      $display("FAIL ready_busy: ready at %0d busy first/end %b%b want %0d 10", c_rdy, b_first, b_end, RDY4);
    end
    vec++;
    if (n_glitch != 0) begin
      err++;
      $display("FAIL mosi_stable: %0d changes while sclk high want 0", n_glitch);
    end
  endtask

  task automatic test_back_to_back;
    int r1, d1;
    logic [39:0] cap1;
    launch(32'h12345678, 1);
    in_data = 32'h9ABCDEF0;
    capture(600);
    cap1 = cap; r1 = c_rise; d1 = c_rdy;
    @(posedge clk);
    #1 in_valid = 0;
    in_data = 32'hDEADBEEF;
    capture(600);
    vec++;
    if (cap1 !== frame_of(32'h12345678)) begin
      err++;
      $display("FAIL b2b_first: got %h want %h", cap1, frame_of(32'h12345678));
    end
    vec++;
    if (cap !== frame_of(32'h9ABCDEF0)) begin
      err++;
      $display("FAIL b2b_second: got %h want %h", cap, frame_of(32'h9ABCDEF0));
    end
    // high time = GAP cycles plus the cycle the next word is accepted in
    vec++;
    if ((d1 - r1) + c_fall != 5) begin
      err++;
      $display("FAIL b2b_gap: cs_n high %0d cycles want 5", (d1 - r1) + c_fall);
    end
  endtask

  task automatic test_reset_mid_frame;
    int nd;
    nd = 0;
    launch(32'hCAFEF00D, 0);
    repeat (86) begin
      @(negedge clk);
      if (o_done) nd++;
    end
    vec++;
    if (o_cs_n !== 1'b0 || o_sclk !== 1'b1) begin
      err++;
      $display("FAIL bit10_active: cs_n=%b sclk=%b want 0 1", o_cs_n, o_sclk);
    end
    #2 rst_n = 0;
    #1;
    vec++;
    if (o_cs_n !== 1'b1 || o_sclk !== 1'b0 || o_busy !== 1'b0) begin
      err++;
      $display("FAIL async_abort: cs_n=%b sclk=%b busy=%b want 1 0 0", o_cs_n, o_sclk, o_busy);
    end
    repeat (3) begin
      @(negedge clk);
      if (o_done) nd++;
    end
    rst_n = 1;
    @(negedge clk);
    if (o_done) nd++;
    vec++;
    if (nd != 0 || o_ready !== 1'b1 || o_cs_n !== 1'b1) begin
      err++;
      $display("FAIL abort_after: done pulses %0d ready=%b cs_n=%b want 0 1 1", nd, o_ready, o_cs_n);
    end
    launch(32'h0000000F, 0);
    capture(600);
    vec++;
    if (cap !== frame_of(32'h0000000F) || c_rise - c_fall != LOW4) begin
      err++;
      $display("FAIL post_reset_frame: got %h low %0d want %h low %0d", cap, c_rise - c_fall, frame_of(32'h0000000F), LOW4);
    end
  endtask

  task automatic test_clk_div1;
    sel = 1;
    launch(32'hA5A5A5A5, 0);
    capture(300);
    vec++;
    if (cap !== frame_of(32'hA5A5A5A5) || c_first != 2) begin
      err++;
      $display("FAIL div1_bits: got %h first rise %0d want %h first rise 2", cap, c_first, frame_of(32'hA5A5A5A5));
    end
    vec++;
    if (c_rise - c_fall != LOW1 || n_tog != 2 * NB) begin
      err++;
      $display("FAIL div1_timing: low %0d toggles %0d want %0d %0d", c_rise - c_fall, n_tog, LOW1, 2 * NB);
    end
    vec++;
    if (n_glitch != 0) begin
      err++;
      $display("FAIL div1_mosi_stable: %0d changes while sclk high want 0", n_glitch);
    end
    sel = 0;
    for (int i = 0; i < 600 && !rdy4; i++) @(negedge clk);
  endtask

  task automatic test_busy_ignored;
    int nlow;
    logic rd;
    nlow = 0;
    rd = 1;
    launch(32'h3C3C1234, 0);
    fork
      capture(600);
      begin
        repeat (40) @(negedge clk);
        in_data = 32'h55550000;
        in_valid = 1;
        rd = o_ready;
        repeat (3) @(negedge clk);
        in_valid = 0;
      end
    join
    repeat (20) begin
      @(negedge clk);
      if (!o_cs_n) nlow++;
    end
    vec++;
    if (cap !== frame_of(32'h3C3C1234) || rd !== 1'b0) begin
      err++;
      $display("FAIL busy_frame: got %h ready=%b want %h ready 0", cap, rd, frame_of(32'h3C3C1234));
    end
    vec++;
    if (nlow != 0 || n_done != 1) begin
      err++;
      $display("FAIL busy_no_extra: cs_n low %0d cycles after, %0d dones want 0 1", nlow, n_done);
    end
  endtask

`ifdef RGBW_TX_CRC_EN
  task automatic test_crc;
    launch(32'h00000001, 0);
    capture(600);
    vec++;
    if (cap !== 40'h00000001_07 || n_bits != 40 || c_rise - c_fall != 324) begin
      err++;
      $display("FAIL crc_one: got %h %0d bits low %0d want 0000000107 40 324", cap, n_bits, c_rise - c_fall);
    end
    launch(32'h00000000, 0);
    capture(600);
    vec++;
    if (cap !== 40'h00000000_00 || n_bits != 40) begin
      err++;
      $display("FAIL crc_zero: got %h %0d bits want 0000000000 40", cap, n_bits);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_reset_mid_frame;
    test_clk_div1;
    test_busy_ignored;
`ifdef RGBW_TX_CRC_EN
    test_crc;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
